// File: rtl/stream_mux_n_pkg.sv
// Shared definitions for the stream_mux_n family.
//   MODE_FIXED / MODE_RR : values of the mode input.
//   wrap_inc()           : modulo-n increment, used for the round-robin pointer.
package stream_mux_n_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Next index after idx in a ring of n entries.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/stream_mux_n_rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts at ptr_i and wraps modulo CHANNELS. The first requesting
// channel found wins.
//   req_i         : request vector, one bit per channel
//   ptr_i         : highest-priority channel index (must be < CHANNELS)
//   grant_oh_o    : one-hot grant (all zero when nobody requests)
//   grant_idx_o   : binary index of the granted channel (0 when no grant)
//   grant_valid_o : a grant was issued
module rr_arbiter #(
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req_i,
  input  logic [SEL_W-1:0]    ptr_i,
  output logic [CHANNELS-1:0] grant_oh_o,
  output logic [SEL_W-1:0]    grant_idx_o,
  output logic                grant_valid_o
);

  int k;

  always_comb begin
    grant_oh_o    = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    k             = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      k = (int'(ptr_i) + i) % CHANNELS;
      if (!grant_valid_o && req_i[k]) begin
        grant_valid_o = 1'b1;
        grant_oh_o[k] = 1'b1;
        grant_idx_o   = SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// Registered N-channel valid/ready stream multiplexer.
// Picks one input stream, either by sel (MODE_FIXED) or by round-robin
// (MODE_RR). The winning word goes into a one-entry output register, tagged
// with its source channel.
//
// Handshake: a word moves on any interface at a rising edge where valid and
// ready are both high. Producers must not make valid depend on ready. Once
// out_valid is raised, the word is held until out_ready is seen.
//
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   mode               : MODE_FIXED (use sel) or MODE_RR (round-robin)
//   sel                : channel index for MODE_FIXED; out-of-range never grants
//   in_data/in_valid   : CHANNELS input streams, channel k at [k*WIDTH +: WIDTH]
//   in_ready           : at most one bit set, for the granted channel
//   out_data/out_chan  : registered word and its source channel
//   out_valid          : output register holds a word
//   out_ready          : consumer accepts
module stream_mux_n
  import stream_mux_n_pkg::*;
#(
  parameter  int WIDTH    = 16,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int PAD_N = 1 << SEL_W;

  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SEL_W-1:0]    out_chan_q, out_chan_d;
  logic                out_valid_q, out_valid_d;
  logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic [PAD_N-1:0]    valid_pad;
  logic                fixed_valid;
  logic [CHANNELS-1:0] fixed_oh;

  logic [CHANNELS-1:0] rr_oh;
  logic [SEL_W-1:0]    rr_idx;
  logic                rr_valid;

  logic [CHANNELS-1:0] grant_oh;
  logic [SEL_W-1:0]    grant_idx;
  logic                grant_valid;
  logic                can_accept;
  logic                xfer;

  // Fixed select. in_valid is zero-padded to the full sel range, so a sel
  // beyond CHANNELS-1 reads a 0 and never grants.
  always_comb begin
    valid_pad                 = '0;
    valid_pad[CHANNELS-1:0]   = in_valid;
    fixed_valid               = valid_pad[sel];
    fixed_oh                  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (fixed_valid && (int'(sel) == i)) fixed_oh[i] = 1'b1;
    end
  end

  rr_arbiter #(.CHANNELS(CHANNELS)) u_rr_arbiter (
    .req_i         (in_valid),
    .ptr_i         (rr_ptr_q),
    .grant_oh_o    (rr_oh),
    .grant_idx_o   (rr_idx),
    .grant_valid_o (rr_valid)
  );

  always_comb begin
    if (mode == MODE_RR) begin
      grant_oh    = rr_oh;
      grant_idx   = rr_idx;
      grant_valid = rr_valid;
    end else begin
      grant_oh    = fixed_oh;
      grant_idx   = sel;
      grant_valid = fixed_valid;
    end
  end

  assign can_accept = !out_valid_q || out_ready;
  assign in_ready   = (reset || !can_accept) ? '0 : grant_oh;
  assign xfer       = grant_valid && can_accept && !reset;

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      // A fill always wins over a drain in the same cycle: the register
      // simply takes the new word.
      out_data_d  = in_data[int'(grant_idx)*WIDTH +: WIDTH];
      out_chan_d  = grant_idx;
      out_valid_d = 1'b1;
      if (mode == MODE_RR) begin
        rr_ptr_d = SEL_W'(wrap_inc(32'(grant_idx), CHANNELS));
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_n.sv
module tb_stream_mux_n;

  localparam int W  = 16;
  localparam int C  = 4;
  localparam int SW = 2;
  localparam int EW = SW + W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // main instance: CHANNELS=4
  logic          mode;
  logic [SW-1:0] sel;
  logic [C*W-1:0] in_data;
  logic [C-1:0]  in_valid, in_ready;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_chan;
  logic          out_valid, out_ready;

  stream_mux_n #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // second instance: CHANNELS=3, for the out-of-range select case
  logic          mode3;
  logic [1:0]    sel3;
  logic [3*W-1:0] in_data3;
  logic [2:0]    in_valid3, in_ready3;
  logic [W-1:0]  out_data3;
  logic [1:0]    out_chan3;
  logic          out_valid3, out_ready3;

  stream_mux_n #(.WIDTH(W), .CHANNELS(3)) dut3 (
    .clk(clk), .reset(reset), .mode(mode3), .sel(sel3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_chan(out_chan3), .out_valid(out_valid3),
    .out_ready(out_ready3)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [SW-1:0] ch, input logic [W-1:0] d);
    exp_q.push_back({ch, d});
  endtask

  // Monitor: every output transfer must match the oldest expected word.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {14'd0, out_chan, out_data}, 32'hFFFF_FFFF);
      end else begin
        check("out_word", {14'd0, out_chan, out_data}, {14'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge. Drives one cycle of inputs and checks
  // in_ready/out_valid mid-cycle, then returns 1 time unit after the next edge.
  task automatic step(input string name, input logic m, input logic [SW-1:0] s,
                      input logic [C-1:0] v, input logic r,
                      input logic [C-1:0] exp_rdy, input logic exp_ov);
    mode = m; sel = s; in_valid = v; out_ready = r;
    @(negedge clk);
    check({name, "_in_ready"}, 32'(in_ready), 32'(exp_rdy));
    check({name, "_out_valid"}, 32'(out_valid), 32'(exp_ov));
    @(posedge clk); #1;
  endtask

  task automatic check_out(input string name, input logic ov, input logic [W-1:0] d,
                           input logic [SW-1:0] ch);
    check({name, "_ov"},   32'(out_valid), 32'(ov));
    check({name, "_data"}, 32'(out_data),  32'(d));
    check({name, "_chan"}, 32'(out_chan),  32'(ch));
  endtask

  localparam logic FX = 1'b0;
  localparam logic RR = 1'b1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    mode = RR; sel = '0; in_valid = 4'hF; out_ready = 1'b1;
    in_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    mode3 = FX; sel3 = '0; in_valid3 = '0; out_ready3 = 1'b1;
    in_data3 = {16'h00C2, 16'h00C1, 16'h00C0};

    // reset with every channel valid
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check_out("rst", 1'b0, 16'h0000, 2'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // round-robin, all valid: 0,1,2,3,0 back to back
    step("rr0", RR, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b0); expect_word(2'd0, 16'h1111);
    step("rr1", RR, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1); expect_word(2'd1, 16'h2222);
    step("rr2", RR, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1); expect_word(2'd2, 16'h3333);
    step("rr3", RR, 2'd0, 4'hF, 1'b1, 4'b1000, 1'b1); expect_word(2'd3, 16'h4444);
    step("rr4", RR, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1); expect_word(2'd0, 16'h1111);
    step("drain0", RR, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b1);

    // fixed select 2 with ch0 also valid
    in_data = {16'h4444, 16'hBEEF, 16'h2222, 16'h1111};
    expect_word(2'd2, 16'hBEEF);
    step("fix2", FX, 2'd2, 4'b0101, 1'b1, 4'b0100, 1'b0);
    check_out("fix2", 1'b1, 16'hBEEF, 2'd2);

    // load 0xA5A5, then stall three cycles while ch1 waits
    in_data = {16'h4444, 16'hA5A5, 16'h2222, 16'h1111};
    expect_word(2'd2, 16'hA5A5);
    step("load_a5", FX, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step("stall", FX, 2'd1, 4'b0010, 1'b0, 4'b0000, 1'b1);
      check_out("stall", 1'b1, 16'hA5A5, 2'd2);
    end
    // release: drain A5A5 and fill ch1 on the same edge
    expect_word(2'd1, 16'h2222);
    step("refill", FX, 2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1);
    check_out("refill", 1'b1, 16'h2222, 2'd1);

    // wrap and skip: rr_ptr=1 still (fixed mode left it alone)
    in_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    expect_word(2'd2, 16'h3333);
    step("to_ptr3", RR, 2'd0, 4'b0100, 1'b1, 4'b0100, 1'b1);   // ptr -> 3
    expect_word(2'd1, 16'h2222);
    step("skip1", RR, 2'd0, 4'b0010, 1'b1, 4'b0010, 1'b1);     // wraps 3->0->1, ptr -> 2
    expect_word(2'd2, 16'h3333);
    step("ptr2", RR, 2'd0, 4'b1110, 1'b1, 4'b0100, 1'b1);      // ptr 2 picks ch2 over ch1
    step("drain1", RR, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b1);

    // reset while a word is held: it must never appear
    step("hold", FX, 2'd0, 4'b0001, 1'b0, 4'b0001, 1'b0);
    reset = 1'b1;
    step("mid_rst", FX, 2'd0, 4'b0001, 1'b0, 4'b0000, 1'b1);
    reset = 1'b0;
    step("post_rst", RR, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b0);
    check_out("post_rst", 1'b0, 16'h0000, 2'd0);
    expect_word(2'd0, 16'h1111);
    step("rst_ptr0", RR, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b0);
    step("drain2", RR, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b1);
    step("idle", RR, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b0);

    // CHANNELS=3: sel=3 is out of range and must never grant
    mode3 = FX; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
    @(negedge clk);
    check("c3_sel3_ready", 32'(in_ready3), 32'h0);
    @(posedge clk); #1;
    check("c3_sel3_ov", 32'(out_valid3), 32'h0);
    sel3 = 2'd2;
    @(negedge clk);
    check("c3_sel2_ready", 32'(in_ready3), 32'b100);
    @(posedge clk); #1;
    check("c3_sel2_ov",   32'(out_valid3), 32'h1);
    check("c3_sel2_chan", 32'(out_chan3),  32'd2);
    check("c3_sel2_data", 32'(out_data3),  32'h00C2);
    mode3 = RR; in_valid3 = 3'b110;
    @(negedge clk);
    check("c3_rr_ready", 32'(in_ready3), 32'b010);
    @(posedge clk); #1;
    check("c3_rr_chan", 32'(out_chan3), 32'd1);
    check("c3_rr_data", 32'(out_data3), 32'h00C1);
    in_valid3 = '0;
    @(posedge clk); #1;

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
